// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, completer FSM encoding and address-range decode.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 9;
  localparam int unsigned APB_DATA_W = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StReady = 2'd2
  } apb_state_e;

  function automatic logic addr_in_range(input logic [7:0] addr, input int unsigned depth);
    return 32'(addr) < depth;
  endfunction

endpackage

// File: rtl/apb_completer_regfile.sv
// Byte-addressed flop array: one synchronous write port, one combinational read port.
module apb_completer_regfile
  import apb_pkg::*;
#(
  parameter int unsigned DATA_W = APB_DATA_W,
  parameter int unsigned DEPTH  = 192
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              we,
  input  logic [7:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [7:0]        raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we && addr_in_range(waddr, DEPTH)) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Unimplemented locations read as zero rather than X.
  assign rdata = addr_in_range(raddr, DEPTH) ? mem_q[raddr] : '0;

endmodule

// File: rtl/apb_completer_mem.sv
// APB completer with local byte memory, programmable wait states, pslverr on out-of-range
// accesses and a sticky protocol-violation flag.
module apb_completer_mem
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W      = APB_ADDR_W,
  parameter int unsigned DATA_W      = APB_DATA_W,
  parameter int unsigned DEPTH       = 192,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic [ADDR_W-1:0] paddr,
  input  logic              pwrite,
  input  logic [DATA_W-1:0] pwdata,
  output logic              pready,
  output logic              pslverr,
  output logic [DATA_W-1:0] prdata,
  output logic              prot_err,
  input  logic              err_clr
);

  localparam logic [3:0] WaitInit = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  apb_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        addr_q, addr_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              prot_err_q, prot_err_d;

  logic              prot_set;
  logic              mem_we;
  logic [7:0]        mem_raddr;
  logic [DATA_W-1:0] mem_rdata;
  logic              unused_paddr;

  // Upper address bits are decoded into psel by the master.
  assign unused_paddr = ^paddr;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    pready_d   = pready_q;
    pslverr_d  = pslverr_q;
    prdata_d   = prdata_q;
    prot_set   = 1'b0;
    mem_we     = 1'b0;
    // Zero-wait reads must use the live setup address; otherwise the captured one.
    mem_raddr  = (state_q == StIdle) ? paddr[7:0] : addr_q;

    case (state_q)
      StIdle: begin
        if (psel && !penable) begin
          addr_d  = paddr[7:0];
          write_d = pwrite;
          wdata_d = pwdata;
          err_d   = !addr_in_range(paddr[7:0], DEPTH);
          if (WAIT_CYCLES == 0) begin
            state_d   = StReady;
            pready_d  = 1'b1;
            pslverr_d = err_d;
            if (!pwrite) prdata_d = err_d ? '0 : mem_rdata;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end else if (psel && penable) begin
          prot_set = 1'b1;
        end
      end
      StWait: begin
        if (!psel) begin
          state_d  = StIdle;
          prot_set = 1'b1;
        end else if (cnt_q == 4'd0) begin
          state_d   = StReady;
          pready_d  = 1'b1;
          pslverr_d = err_q;
          if (!write_q) prdata_d = err_q ? '0 : mem_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StReady: begin
        state_d   = StIdle;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        if (psel && penable) begin
          mem_we = write_q && !err_q;
        end else if (!psel) begin
          prot_set = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Request must stay stable from setup until completion.
    if ((state_q == StWait || state_q == StReady) && psel &&
        ((paddr[7:0] != addr_q) || (pwrite != write_q) || (write_q && (pwdata != wdata_q)))) begin
      prot_set = 1'b1;
    end

    prot_err_d = prot_set ? 1'b1 : (err_clr ? 1'b0 : prot_err_q);
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= '0;
      prot_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      prdata_q   <= prdata_d;
      prot_err_q <= prot_err_d;
    end
  end

  apb_completer_regfile #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_regfile (
    .pclk   (pclk),
    .presetn(presetn),
    .we     (mem_we),
    .waddr  (addr_q),
    .wdata  (wdata_q),
    .raddr  (mem_raddr),
    .rdata  (mem_rdata)
  );

  assign pready   = pready_q;
  assign pslverr  = pslverr_q;
  assign prdata   = prdata_q;
  assign prot_err = prot_err_q;

endmodule

// File: tb/tb_apb_completer_mem.sv
// Bench for apb_completer_mem: a zero-wait and a three-wait instance share one APB bus,
// checked against a byte-array model of each completer.
module tb_apb_completer_mem;

  localparam int unsigned DEPTH = 192;

  logic       pclk = 1'b0;
  logic       presetn;
  logic [1:0] psel_v;
  logic       penable;
  logic [8:0] paddr;
  logic       pwrite;
  logic [7:0] pwdata;
  logic       err_clr;
  logic [1:0] pready_v, pslverr_v, prot_err_v;
  logic [7:0] prdata0, prdata3;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem_m   [2][256];
  logic [7:0] last_rd [2];

  always #5 pclk = ~pclk;

  apb_completer_mem #(.ADDR_W(9), .DATA_W(8), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_w0 (
    .pclk(pclk), .presetn(presetn), .psel(psel_v[0]), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata), .pready(pready_v[0]), .pslverr(pslverr_v[0]),
    .prdata(prdata0), .prot_err(prot_err_v[0]), .err_clr(err_clr)
  );

  apb_completer_mem #(.ADDR_W(9), .DATA_W(8), .DEPTH(DEPTH), .WAIT_CYCLES(3)) dut_w3 (
    .pclk(pclk), .presetn(presetn), .psel(psel_v[1]), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata), .pready(pready_v[1]), .pslverr(pslverr_v[1]),
    .prdata(prdata3), .prot_err(prot_err_v[1]), .err_clr(err_clr)
  );

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 256; i++) mem_m[d][i] = 8'h00;
      last_rd[d] = 8'h00;
    end
  endtask

  task automatic bus_idle();
    psel_v  = 2'b00;
    penable = 1'b0;
  endtask

  // Drives one transfer starting right after a clock edge; returns just after the completing
  // edge so the caller may issue the next setup back-to-back. cyc is the access cycle index
  // in which pready was seen (99 on timeout).
  task automatic xfer(input int d, input logic wr, input logic [8:0] a, input logic [7:0] wd,
                      output logic [7:0] rd, output logic se, output int cyc);
    psel_v    = 2'b00;
    psel_v[d] = 1'b1;
    penable   = 1'b0;
    paddr     = a;
    pwrite    = wr;
    pwdata    = wd;
    rd        = 8'h00;
    se        = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    cyc = 0;
    while (cyc < 20) begin
      cyc++;
      @(negedge pclk);
      if (pready_v[d]) begin
        rd = (d == 1) ? prdata3 : prdata0;
        se = pslverr_v[d];
        @(posedge pclk); #1;
        return;
      end
      @(posedge pclk); #1;
    end
    cyc = 99;
    bus_idle();
  endtask

  // Transfer plus model prediction: in range per DEPTH, out-of-range reads return 0,
  // writes leave prdata at the last read value.
  task automatic mxfer(input int d, input logic wr, input logic [8:0] a, input logic [7:0] wd,
                       output logic [7:0] rd, output logic se, output int cyc,
                       output logic [7:0] exp_rd, output logic exp_se, output int exp_cyc);
    logic inr;
    xfer(d, wr, a, wd, rd, se, cyc);
    inr     = (int'(a[7:0]) < DEPTH);
    exp_se  = !inr;
    exp_cyc = (d == 1) ? 4 : 1;
    if (wr) begin
      exp_rd = last_rd[d];
      if (inr) mem_m[d][a[7:0]] = wd;
    end else begin
      exp_rd = inr ? mem_m[d][a[7:0]] : 8'h00;
      last_rd[d] = exp_rd;
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (pready_v[d] !== 1'b0 || pslverr_v[d] !== 1'b0 || prot_err_v[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_flags dut%0d: got pready=%b pslverr=%b prot_err=%b want 0/0/0",
                 d, pready_v[d], pslverr_v[d], prot_err_v[d]);
      end
    end
    checks++;
    if (prdata0 !== 8'h00 || prdata3 !== 8'h00) begin
      errors++;
      $display("FAIL reset_prdata: got %h/%h want 00/00", prdata0, prdata3);
    end
  endtask

  task automatic test_basic();
    logic [7:0] rd, erd;
    logic se, ese;
    int cyc, ecyc;
    mxfer(0, 1'b1, 9'h010, 8'h5A, rd, se, cyc, erd, ese, ecyc);
    checks++;
    if (cyc !== ecyc || se !== 1'b0) begin
      errors++; $display("FAIL w0_write: got cyc=%0d se=%b want cyc=%0d se=0", cyc, se, ecyc);
    end
    mxfer(0, 1'b0, 9'h010, 8'h00, rd, se, cyc, erd, ese, ecyc);
    checks++;
    if (cyc !== 1 || se !== 1'b0 || rd !== 8'h5A) begin
      errors++; $display("FAIL w0_read: got cyc=%0d se=%b rd=%h want 1/0/5a", cyc, se, rd);
    end
    mxfer(1, 1'b1, 9'h020, 8'hC3, rd, se, cyc, erd, ese, ecyc);
    checks++;
    if (cyc !== 4 || se !== 1'b0) begin
      errors++; $display("FAIL w3_write: got cyc=%0d se=%b want 4/0", cyc, se);
    end
    mxfer(1, 1'b0, 9'h020, 8'h00, rd, se, cyc, erd, ese, ecyc);
    checks++;
    if (cyc !== 4 || se !== 1'b0 || rd !== 8'hC3) begin
      errors++; $display("FAIL w3_read: got cyc=%0d se=%b rd=%h want 4/0/c3", cyc, se, rd);
    end
    bus_idle();
    @(posedge pclk); #1;
  endtask

  task automatic test_range();
    logic [7:0] rd, erd;
    logic se, ese;
    int cyc, ecyc;
    mxfer(0, 1'b1, 9'h0C0, 8'hFF, rd, se, cyc, erd, ese, ecyc);
    checks++;
    if (se !== 1'b1 || cyc !== 1) begin
      errors++; $display("FAIL oor_write: got se=%b cyc=%0d want 1/1", se, cyc);
    end
    mxfer(0, 1'b0, 9'h0C0, 8'h00, rd, se, cyc, erd, ese, ecyc);
    checks++;
    if (se !== 1'b1 || rd !== 8'h00) begin
      errors++; $display("FAIL oor_read: got se=%b rd=%h want 1/00", se, rd);
    end
    mxfer(0, 1'b0, 9'h0BF, 8'h00, rd, se, cyc, erd, ese, ecyc);
    checks++;
    if (se !== 1'b0 || rd !== 8'h00) begin
      errors++; $display("FAIL last_in_range: got se=%b rd=%h want 0/00", se, rd);
    end
    bus_idle();
    @(posedge pclk); #1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd1, rd2, erd;
    logic se, ese;
    int cyc, ecyc;
    mxfer(0, 1'b1, 9'h001, 8'h11, rd1, se, cyc, erd, ese, ecyc);
    mxfer(0, 1'b1, 9'h002, 8'h22, rd1, se, cyc, erd, ese, ecyc);
    mxfer(0, 1'b0, 9'h001, 8'h00, rd1, se, cyc, erd, ese, ecyc);
    mxfer(0, 1'b0, 9'h002, 8'h00, rd2, se, cyc, erd, ese, ecyc);
    bus_idle();
    checks++;
    if (rd1 !== 8'h11 || rd2 !== 8'h22 || cyc !== 1) begin
      errors++; $display("FAIL b2b_data: got %h/%h cyc=%0d want 11/22 cyc=1", rd1, rd2, cyc);
    end
    @(negedge pclk);
    checks++;
    if (prot_err_v[0] !== 1'b0) begin
      errors++; $display("FAIL b2b_prot_err: got %b want 0", prot_err_v[0]);
    end
    @(posedge pclk); #1;
  endtask

  task automatic test_random();
    logic [7:0] rd, erd, wd;
    logic [8:0] a;
    logic se, ese, wr;
    int cyc, ecyc, d;
    for (int i = 0; i < 80; i++) begin
      d  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      wd = 8'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? 9'(188 + $urandom_range(0, 7)) :
                                         9'($urandom_range(0, 511));
      mxfer(d, wr, a, wd, rd, se, cyc, erd, ese, ecyc);
      checks++;
      if (rd !== erd) begin
        errors++; $display("FAIL rand_prdata #%0d dut%0d wr=%b a=%h: got %h want %h",
                           i, d, wr, a, rd, erd);
      end
      checks++;
      if (se !== ese) begin
        errors++; $display("FAIL rand_pslverr #%0d a=%h: got %b want %b", i, a, se, ese);
      end
      checks++;
      if (cyc !== ecyc) begin
        errors++; $display("FAIL rand_latency #%0d dut%0d: got %0d want %0d", i, d, cyc, ecyc);
      end
      if ($urandom_range(0, 2) == 0) begin
        bus_idle();
        @(posedge pclk); #1;
      end
    end
    bus_idle();
    @(negedge pclk);
    checks++;
    if (prot_err_v !== 2'b00) begin
      errors++; $display("FAIL rand_prot_err: got %b want 00", prot_err_v);
    end
    @(posedge pclk); #1;
  endtask

  task automatic test_violations();
    logic [7:0] rd, erd;
    logic se, ese;
    int cyc, ecyc;
    // Access phase with no setup on the three-wait completer.
    psel_v = 2'b10; penable = 1'b1; paddr = 9'h030;
    @(posedge pclk); #1;
    bus_idle();
    @(negedge pclk);
    checks++;
    if (prot_err_v !== 2'b10 || pready_v[1] !== 1'b0) begin
      errors++; $display("FAIL no_setup: got prot_err=%b pready=%b want 10/0",
                         prot_err_v, pready_v[1]);
    end
    // Address changes during WAIT while err_clr is asserted: set wins.
    @(posedge pclk); #1;
    psel_v = 2'b10; penable = 1'b0; paddr = 9'h030; pwrite = 1'b1; pwdata = 8'hA5;
    @(posedge pclk); #1;
    penable = 1'b1;
    paddr   = 9'h031;
    err_clr = 1'b1;
    @(posedge pclk); #1;
    err_clr = 1'b0;
    @(negedge pclk);
    checks++;
    if (prot_err_v[1] !== 1'b1) begin
      errors++; $display("FAIL set_over_clr: got %b want 1", prot_err_v[1]);
    end
    cyc = 0;
    while (cyc < 10 && pready_v[1] !== 1'b1) begin
      @(posedge pclk); #1;
      @(negedge pclk);
      cyc++;
    end
    checks++;
    if (pready_v[1] !== 1'b1) begin
      errors++; $display("FAIL unstable_complete: got pready=0 want 1");
    end
    @(posedge pclk); #1;
    bus_idle();
    mem_m[1][8'h30] = 8'hA5;
    mxfer(1, 1'b0, 9'h030, 8'h00, rd, se, cyc, erd, ese, ecyc);
    checks++;
    if (rd !== 8'hA5) begin
      errors++; $display("FAIL captured_addr: got %h want a5", rd);
    end
    mxfer(1, 1'b0, 9'h031, 8'h00, rd, se, cyc, erd, ese, ecyc);
    checks++;
    if (rd !== erd) begin
      errors++; $display("FAIL changed_addr_untouched: got %h want %h", rd, erd);
    end
    bus_idle();
    @(posedge pclk); #1;
    err_clr = 1'b1;
    @(posedge pclk); #1;
    err_clr = 1'b0;
    @(negedge pclk);
    checks++;
    if (prot_err_v !== 2'b00) begin
      errors++; $display("FAIL err_clr: got %b want 00", prot_err_v);
    end
    @(posedge pclk); #1;
  endtask

  task automatic test_reset_mid();
    logic [7:0] rd, erd;
    logic se, ese;
    int cyc, ecyc;
    mxfer(1, 1'b1, 9'h006, 8'h99, rd, se, cyc, erd, ese, ecyc);
    mxfer(1, 1'b0, 9'h006, 8'h00, rd, se, cyc, erd, ese, ecyc);
    checks++;
    if (rd !== 8'h99) begin
      errors++; $display("FAIL pre_reset_read: got %h want 99", rd);
    end
    psel_v = 2'b10; penable = 1'b0; paddr = 9'h005; pwrite = 1'b1; pwdata = 8'h77;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    presetn = 1'b0;
    #1;
    checks++;
    if (pready_v[1] !== 1'b0 || pslverr_v[1] !== 1'b0 || prdata3 !== 8'h00 ||
        prot_err_v[1] !== 1'b0) begin
      errors++; $display("FAIL async_reset: got pready=%b pslverr=%b prdata=%h prot_err=%b",
                         pready_v[1], pslverr_v[1], prdata3, prot_err_v[1]);
    end
    bus_idle();
    model_clear();
    @(posedge pclk); #1;
    presetn = 1'b1;
    @(posedge pclk); #1;
    mxfer(1, 1'b0, 9'h005, 8'h00, rd, se, cyc, erd, ese, ecyc);
    checks++;
    if (rd !== 8'h00 || se !== 1'b0) begin
      errors++; $display("FAIL abandoned_write: got rd=%h se=%b want 00/0", rd, se);
    end
    mxfer(1, 1'b0, 9'h006, 8'h00, rd, se, cyc, erd, ese, ecyc);
    checks++;
    if (rd !== erd) begin
      errors++; $display("FAIL mem_cleared: got %h want %h", rd, erd);
    end
    bus_idle();
    @(posedge pclk); #1;
  endtask

  initial begin
    presetn = 1'b0;
    err_clr = 1'b0;
    paddr   = '0;
    pwrite  = 1'b0;
    pwdata  = '0;
    bus_idle();
    model_clear();
    repeat (2) @(posedge pclk);
    #1;
    test_reset();
    presetn = 1'b1;
    @(posedge pclk); #1;
    test_basic();
    test_range();
    test_back_to_back();
    test_random();
    test_violations();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
